// File: rtl/pool_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pool_frame_ctrl
// Frame sequencer for the 2x2 max-pool/ReLU stage. It sits between the conv
// engine and the pooler. It opens a frame on start and clears the pooler.
// Conv pixels are forwarded only while the frame is running. The block tracks
// the raster position of the next input pixel and counts the pooled results.
// It pulses frame_done on normal completion. Any out-of-frame traffic raises a
// sticky error.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          synchronous reset, active low
//   start          1-cycle pulse, opens a frame (only honoured in IDLE)
//   abort          cancels the current frame (ignored in IDLE)
//   conv_valid     conv engine presents one pixel
//   relu_valid     pooler presents one pooled result
//   pool_valid_in  conv_valid gated by RUN
//   pool_rst_n     active-low synchronous clear to the pooler
//   out_valid      accepted relu_valid (RUN or DRAIN, count not yet full)
//   out_idx        raster index of the pooled result under out_valid
//   col, row       position of the next input pixel
//   busy           high in every state except IDLE
//   frame_done     1-cycle pulse on normal completion
//   seq_err        sticky out-of-frame traffic flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module pool_frame_ctrl #(
  parameter int WIDTH   = 24,
  parameter int HEIGHT  = 24,
  parameter int COL_BIT = 5,
  parameter int ROW_BIT = 5,
  parameter int OUT_BIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               conv_valid,
  input  logic               relu_valid,
  output logic               pool_valid_in,
  output logic               pool_rst_n,
  output logic               out_valid,
  output logic [OUT_BIT-1:0] out_idx,
  output logic [COL_BIT-1:0] col,
  output logic [ROW_BIT-1:0] row,
  output logic               busy,
  output logic               frame_done,
  output logic               seq_err
);

  localparam int TOTAL = (WIDTH / 2) * (HEIGHT / 2);
  localparam logic [COL_BIT-1:0] COL_LAST  = COL_BIT'(WIDTH - 1);
  localparam logic [ROW_BIT-1:0] ROW_LAST  = ROW_BIT'(HEIGHT - 1);
  // One spare bit so the counter can hold TOTAL even when TOTAL == 2^OUT_BIT.
  localparam logic [OUT_BIT:0]   CNT_TOTAL = (OUT_BIT + 1)'(TOTAL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [COL_BIT-1:0] col_q, col_d;
  logic [ROW_BIT-1:0] row_q, row_d;
  logic [OUT_BIT:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic in_run_s, in_drain_s, cnt_full_s, relu_ok_s, err_now_s;

  assign in_run_s   = (state_q == S_RUN);
  assign in_drain_s = (state_q == S_DRAIN);
  assign cnt_full_s = (cnt_q == CNT_TOTAL);
  assign relu_ok_s  = relu_valid & (in_run_s | in_drain_s) & ~cnt_full_s;
  assign err_now_s  = (conv_valid & ~in_run_s)
                    | (relu_valid & ~(in_run_s | in_drain_s))
                    | (relu_valid & cnt_full_s);

  // Next-state logic for the FSM, raster counters, output count and error flag.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    err_d   = err_q | err_now_s;

    if (relu_ok_s) begin
      cnt_d = cnt_q + {{OUT_BIT{1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          col_d   = {COL_BIT{1'b0}};
          row_d   = {ROW_BIT{1'b0}};
          cnt_d   = {(OUT_BIT + 1){1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (conv_valid) begin
          if (col_q == COL_LAST) begin
            col_d = {COL_BIT{1'b0}};
            if (row_q == ROW_LAST) begin
              row_d   = {ROW_BIT{1'b0}};
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + {{(ROW_BIT - 1){1'b0}}, 1'b1};
            end
          end else begin
            col_d = col_q + {{(COL_BIT - 1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_RUN;
        end
      end
      // The registered count is checked, so a count completed on the last
      // input edge still spends one cycle here.
      S_DRAIN: begin
        if (cnt_full_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition out of a busy state.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_ABORT;
      col_d   = {COL_BIT{1'b0}};
      row_d   = {ROW_BIT{1'b0}};
      cnt_d   = {(OUT_BIT + 1){1'b0}};
    end else begin
      state_d = state_d;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= {COL_BIT{1'b0}};
      row_q   <= {ROW_BIT{1'b0}};
      cnt_q   <= {(OUT_BIT + 1){1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pool_valid_in = conv_valid & in_run_s;
  assign pool_rst_n    = rst_n & ~((state_q == S_CLEAR) | (state_q == S_ABORT));
  assign out_valid     = relu_ok_s;
  assign out_idx       = cnt_q[OUT_BIT-1:0];
  assign col           = col_q;
  assign row           = row_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign seq_err       = err_q;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
module tb_pool_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CB = 2;
  localparam int RB = 2;
  localparam int OB = 3;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, conv_valid;
  logic          relu_model, relu_force, relu_valid;
  logic          pool_valid_in, pool_rst_n, out_valid, busy, frame_done, seq_err;
  logic [OB-1:0] out_idx;
  logic [CB-1:0] col;
  logic [RB-1:0] row;

  assign relu_valid = relu_model | relu_force;

  pool_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .COL_BIT(CB), .ROW_BIT(RB), .OUT_BIT(OB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .conv_valid(conv_valid), .relu_valid(relu_valid),
    .pool_valid_in(pool_valid_in), .pool_rst_n(pool_rst_n),
    .out_valid(out_valid), .out_idx(out_idx), .col(col), .row(row),
    .busy(busy), .frame_done(frame_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int done_cnt = 0;
  int cyc = 0;
  int last_ov_cyc = -100;
  int done_cyc = -100;
  int gaps [16] = '{1, 0, 3, 2, 0, 1, 2, 3, 0, 0, 1, 3, 2, 1, 0, 2};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pooler model: a result appears the cycle after the bottom-right pixel of each 2x2 window.
  initial begin : pooler
    int pcnt;
    logic pv, pr;
    pcnt = 0;
    relu_model = 1'b0;
    forever begin
      @(negedge clk);
      pv = pool_valid_in;
      pr = pool_rst_n;
      @(posedge clk);
      #1;
      relu_model = 1'b0;
      if (pr === 1'b0) begin
        pcnt = 0;
      end else if (pv === 1'b1) begin
        if (((pcnt / W) % 2 == 1) && (pcnt % 2 == 1)) relu_model = 1'b1;
        pcnt = (pcnt + 1) % (W * H);
      end
    end
  end

  // Monitor: pops one expected index per out_valid and counts frame_done pulses.
  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        last_ov_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_idx", int'(out_idx), e);
        end
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_busy", int'(busy), 1);
    chk("clear_pool_rst_n", int'(pool_rst_n), 0);
    chk("start_clears_seq_err", int'(seq_err), 0);
    step();
    chk("run_pool_rst_n", int'(pool_rst_n), 1);
  endtask

  // Drives n pixels in raster order; pushes the expected pooled index when a window completes.
  task automatic run_frame(input int n, input bit use_gaps, input int start_at);
    for (int k = 0; k < n; k++) begin
      if (k == start_at) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_run_busy", int'(busy), 1);
      end
      chk("col", int'(col), k % W);
      chk("row", int'(row), (k / W) % H);
      conv_valid = 1'b1;
      #1;
      chk("pool_valid_in", int'(pool_valid_in), 1);
      if (((k / W) % 2 == 1) && (k % 2 == 1)) exp_q.push_back((k / (2 * W)) * (W / 2) + (k % W) / 2);
      step();
      conv_valid = 1'b0;
      if (use_gaps) repeat (gaps[k]) step();
    end
  endtask

  task automatic end_frame(input string nm, input int d0);
    repeat (6) step();
    chk({nm, "_done_cnt"}, done_cnt - d0, 1);
    chk({nm, "_done_latency"}, done_cyc - last_ov_cyc, 2);
    chk({nm, "_seq_err"}, int'(seq_err), 0);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_col_row"}, int'(col) + int'(row), 0);
  endtask

  initial begin : stim
    int d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; conv_valid = 1'b0; relu_force = 1'b0;
    repeat (2) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_pool_rst_n", int'(pool_rst_n), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_pool_rst_n", int'(pool_rst_n), 1);
    step();

    // 1: back-to-back frame
    d0 = done_cnt;
    do_start();
    run_frame(16, 1'b0, -1);
    end_frame("t1", d0);

    // 2: frame with gaps between pixels
    d0 = done_cnt;
    do_start();
    run_frame(16, 1'b1, -1);
    end_frame("t2", d0);

    // 3: stray pixel while idle
    conv_valid = 1'b1;
    #1;
    chk("t3_pool_valid_in_idle", int'(pool_valid_in), 0);
    step();
    conv_valid = 1'b0;
    chk("t3_seq_err_set", int'(seq_err), 1);
    d0 = done_cnt;
    do_start();
    run_frame(16, 1'b0, -1);
    end_frame("t3", d0);

    // 4: abort after 9 pixels, then a clean frame
    d0 = done_cnt;
    do_start();
    run_frame(9, 1'b0, -1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_busy", int'(busy), 1);
    chk("t4_abort_pool_rst_n", int'(pool_rst_n), 0);
    chk("t4_abort_col_row", int'(col) + int'(row), 0);
    step();
    chk("t4_idle_busy", int'(busy), 0);
    chk("t4_idle_pool_rst_n", int'(pool_rst_n), 1);
    repeat (4) step();
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_queue_empty", exp_q.size(), 0);
    d0 = done_cnt;
    do_start();
    run_frame(16, 1'b0, -1);
    end_frame("t4b", d0);

    // 5: start during RUN ignored, then an extra result after the frame
    d0 = done_cnt;
    do_start();
    run_frame(16, 1'b0, 7);
    end_frame("t5", d0);
    relu_force = 1'b1;
    #1;
    chk("t5_extra_out_valid", int'(out_valid), 0);
    step();
    relu_force = 1'b0;
    chk("t5_extra_seq_err", int'(seq_err), 1);

    // 6: reset mid-RUN, then a normal frame
    do_start();
    run_frame(6, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pool_rst_n", int'(pool_rst_n), 0);
    step();
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_col_row", int'(col) + int'(row), 0);
    chk("t6_rst_seq_err", int'(seq_err), 0);
    chk("t6_rst_frame_done", int'(frame_done), 0);
    chk("t6_rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    #1;
    chk("t6_release_pool_rst_n", int'(pool_rst_n), 1);
    step();
    d0 = done_cnt;
    do_start();
    run_frame(16, 1'b0, -1);
    end_frame("t6", d0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
